// File: rtl/ex_seq_ctrl.sv
// Sequencer and stall controller for multi-cycle EX-stage operations.
// Steps a radix-2 divider and a two-phase multiply-accumulate, and merges stall requests.
module ex_seq_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stallreq_id,
    input  logic             div_req,
    input  logic             div_by_zero,
    input  logic             mac_req,
    output logic [5:0]       stall_o,
    output logic             stallreq_ex_o,
    output logic             div_load_o,
    output logic             div_step_o,
    output logic [CNT_W-1:0] div_cnt_o,
    output logic             div_done_o,
    output logic             div_zero_o,
    output logic             mac_phase_o,
    output logic             mac_done_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_END, MAC_P2} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             zero_q, zero_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            zero_q <= zero_nxt;
        end
    end

    // The counter only survives while staying in DIV_RUN, so it is 0 everywhere else.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        zero_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!flush) begin
                    if (div_req) begin
                        if (div_by_zero) begin
                            state_nxt = DIV_END;
                            zero_nxt  = 1'b1;
                        end else begin
                            state_nxt = DIV_RUN;
                        end
                    end else if (mac_req) begin
                        state_nxt = MAC_P2;
                    end
                end
            end
            DIV_RUN: begin
                if (flush)            state_nxt = IDLE;
                else if (cnt == LAST) state_nxt = DIV_END;
                else                  cnt_nxt   = cnt + 1'b1;
            end
            DIV_END: state_nxt = IDLE;
            MAC_P2:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset is treated like flush for the request-driven outputs so nothing leaks during rst.
    assign div_load_o    = !rst && !flush && (state == IDLE) && div_req && !div_by_zero;
    assign stallreq_ex_o = !rst && (((state == IDLE) && (div_req || mac_req) && !flush)
                                    || (state == DIV_RUN));

    assign div_step_o  = (state == DIV_RUN);
    assign div_cnt_o   = cnt;
    assign div_done_o  = (state == DIV_END);
    assign div_zero_o  = (state == DIV_END) && zero_q;
    assign mac_phase_o = (state == MAC_P2);
    assign mac_done_o  = (state == MAC_P2);
    assign busy_o      = (state != IDLE);

    always_comb begin
        stall_o = 6'b000000;
        if (rst || flush)       stall_o = 6'b000000;
        else if (stallreq_ex_o) stall_o = 6'b001111;
        else if (stallreq_id)   stall_o = 6'b000111;
    end

endmodule
